save_stream_reader: RTL and testbench
=====================================

Name: save_stream_reader

Overview:
- Read-side counterpart of the save loader path.
- On a start pulse, walks the backup (cart) RAM from address 0 and packs 16-bit halfwords into 32-bit little-endian words.
- When RTC is in use, appends a 3-word RTC trailer in the same layout the save loader parses.
- Delivers words over a valid/ready stream to the bridge-side unloader FIFO, all in the clk_sys domain.

Parameters:
- READ_LATENCY, 2, clk_sys cycles from bk_rd/bk_addr to valid bk_q (1..15).
- ADDR_W, 17, halfword address width of backup RAM.

Ports:
- clk_sys  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begin a dump; ignored while busy.
- abort  in  1  single-cycle pulse; terminate dump, return to IDLE.
- save_size_bytes  in  18  RAM save size in bytes (0, 512, 2048, 8192, 32768, 65536 or 131072).
- rtc_inuse  in  1  append RTC trailer.
- rtc_timestamp  in  32  RTC timestamp.
- rtc_savedtime  in  48  RTC saved time.
- bk_rd  out  1  backup RAM read strobe.
- bk_addr  out  17  backup RAM halfword address.
- bk_q  in  16  backup RAM read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  stream word.
- out_last  out  1  marks final word.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse at completion or abort.

Behaviour:
- Reset values: bk_rd=0, bk_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. The FSM is in IDLE.
- On start in IDLE:
  - Latch save_size_bytes, rtc_inuse, rtc_timestamp and rtc_savedtime. The snapshot is held for the whole dump, so input changes mid-dump have no effect.
  - Total words = save_size_bytes/4 + (rtc_inuse ? 3 : 0), computed in 16 bits.
- If total words = 0: go to FINISH next cycle (done pulse only, no stream words).
- FSM states: IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, EMIT, RTC_EMIT, FINISH.
- RD_LO:
  - bk_rd=1 for one cycle, bk_addr = 2n (n = word index).
  - WAIT_LO counts READ_LATENCY cycles, then captures bk_q into out_data[15:0].
- RD_HI / WAIT_HI: same as RD_LO/WAIT_LO with bk_addr = 2n+1; capture into out_data[31:16].
- EMIT:
  - out_valid=1; out_data is held stable until out_ready.
  - On out_valid & out_ready: n++.
  - If n reaches save_size_bytes/4: go to RTC_EMIT when rtc_inuse, else FINISH. Otherwise go to RD_LO.
- RTC_EMIT (no RAM access), three words:
  - k=0: rtc_timestamp.
  - k=1: rtc_savedtime[31:0].
  - k=2: {16'hFFFF, rtc_savedtime[47:32]}.
  - Each word is held until accepted.
- out_last=1 with the final word of the dump only, whether that is a RAM word or RTC word 2.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- busy=1 in every state except IDLE.
- Back-pressure: out_ready low stalls in EMIT/RTC_EMIT indefinitely. No RAM read is issued while a word is pending.
- abort:
  - Highest priority in any non-IDLE state.
  - Next cycle: out_valid=0, bk_rd=0, then FINISH (done pulse). Not out_last.
  - abort and start in the same cycle in IDLE: start is ignored.
- Throughput: one word per 2*(READ_LATENCY+1)+1 cycles when out_ready is held high.
- Asynchronous reset mid-dump: immediate return to reset values; no done pulse.

Decomposition:
- Package save_pkg:
  - state enum.
  - RTC_TRAILER_WORDS=3.
  - RTC_PAD=16'hFFFF.
  - Function that computes total words from size and rtc flag.
- Sub-module save_rtc_trailer (combinational mux of the latched RTC snapshot by index k) is natural.
- RAM fetch and word packing stay in the top module.

Test Plan:
- Word packing: save_size=512, rtc_inuse=0, RAM[h]=h, out_ready=1 -> 128 words; word0=32'h0001_0000, word127=32'h00FF_00FE with out_last=1; done pulse one cycle later.
- RTC trailer: save_size=2048, rtc_inuse=1, timestamp=32'h1234_5678, savedtime=48'hAAAA_BBBB_CCCC -> 515 words; words 512..514 = 12345678, BBBBCCCC, FFFFAAAA; out_last only on word 514.
- Empty dump: save_size=0, rtc_inuse=0 -> no out_valid; done 2 cycles after start.
- RTC-only dump: save_size=0, rtc_inuse=1 -> 3 RTC words, the third with out_last.
- Back-pressure: out_ready low for 20 cycles at word 5 -> out_data and out_valid stable, no bk_rd during the stall; stream resumes intact.
- Abort and reset: abort at word 10 -> out_valid drops next cycle, done pulses once, busy=0; reset_n low mid-dump -> all outputs zero immediately with no done; start while busy -> ignored, word count unchanged.

Source files
------------

// File: rtl/save_pkg.sv
// Shared types and helpers for the save-RAM read stream: FSM states,
// RTC trailer layout constants and word-count arithmetic.
package save_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_WAIT_LO,
    ST_RD_HI,
    ST_WAIT_HI,
    ST_EMIT,
    ST_RTC_EMIT,
    ST_FINISH
  } state_t;

  localparam int          RTC_TRAILER_WORDS = 3;
  localparam logic [15:0] RTC_PAD           = 16'hFFFF;

  // Number of 32-bit words that come from backup RAM.
  function automatic logic [15:0] ram_words(input logic [17:0] size_bytes);
    return 16'(size_bytes >> 2);
  endfunction

  // Full dump length in words, RTC trailer included when enabled.
  function automatic logic [15:0] total_words(input logic [17:0] size_bytes,
                                              input logic        rtc_inuse);
    return ram_words(size_bytes) + (rtc_inuse ? 16'(RTC_TRAILER_WORDS) : 16'd0);
  endfunction

endpackage

// File: rtl/save_rtc_trailer.sv
// Selects one word of the RTC trailer from the latched RTC snapshot,
// in the same order the save loader expects to parse it back.
module save_rtc_trailer
  import save_pkg::*;
(
  input  logic [1:0]  k,
  input  logic [31:0] rtc_timestamp,
  input  logic [47:0] rtc_savedtime,
  output logic [31:0] word
);

  always_comb begin
    word = 32'd0;
    case (k)
      2'd0:    word = rtc_timestamp;
      2'd1:    word = rtc_savedtime[31:0];
      2'd2:    word = {RTC_PAD, rtc_savedtime[47:32]};
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/save_stream_reader.sv
// Dumps backup RAM (plus optional RTC trailer) as a valid/ready stream of
// little-endian 32-bit words, two halfword reads per word.
module save_stream_reader
  import save_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 17
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [17:0]       save_size_bytes,
  input  logic              rtc_inuse,
  input  logic [31:0]       rtc_timestamp,
  input  logic [47:0]       rtc_savedtime,
  output logic              bk_rd,
  output logic [ADDR_W-1:0] bk_addr,
  input  logic [15:0]       bk_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] LAT_LAST   = 4'(READ_LATENCY - 1);
  localparam logic [1:0] RTC_LAST_K = 2'(RTC_TRAILER_WORDS - 1);

  state_t      state_reg, state_next;
  logic [17:0] size_bytes_reg, size_bytes_next;
  logic        rtc_inuse_reg, rtc_inuse_next;
  logic [31:0] timestamp_reg, timestamp_next;
  logic [47:0] savedtime_reg, savedtime_next;
  logic [15:0] n_reg, n_next;
  logic [1:0]  k_reg, k_next;
  logic [3:0]  wait_reg, wait_next;
  logic [31:0] data_reg, data_next;

  logic        hi_sel;
  logic [15:0] ram_word_cnt;
  logic [15:0] n_inc;
  logic [31:0] trailer_word;

  assign ram_word_cnt = ram_words(size_bytes_reg);
  assign n_inc        = n_reg + 16'd1;
  assign bk_addr      = {n_reg[ADDR_W-2:0], hi_sel};

  save_rtc_trailer u_rtc_trailer (
    .k             (k_reg),
    .rtc_timestamp (timestamp_reg),
    .rtc_savedtime (savedtime_reg),
    .word          (trailer_word)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      size_bytes_reg <= '0;
      rtc_inuse_reg  <= 1'b0;
      timestamp_reg  <= '0;
      savedtime_reg  <= '0;
      n_reg          <= '0;
      k_reg          <= '0;
      wait_reg       <= '0;
      data_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      size_bytes_reg <= size_bytes_next;
      rtc_inuse_reg  <= rtc_inuse_next;
      timestamp_reg  <= timestamp_next;
      savedtime_reg  <= savedtime_next;
      n_reg          <= n_next;
      k_reg          <= k_next;
      wait_reg       <= wait_next;
      data_reg       <= data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    size_bytes_next = size_bytes_reg;
    rtc_inuse_next  = rtc_inuse_reg;
    timestamp_next  = timestamp_reg;
    savedtime_next  = savedtime_reg;
    n_next          = n_reg;
    k_next          = k_reg;
    wait_next       = wait_reg;
    data_next       = data_reg;
    hi_sel          = 1'b0;
    bk_rd           = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    out_data        = data_reg;
    busy            = (state_reg != ST_IDLE);
    done            = (state_reg == ST_FINISH);

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          size_bytes_next = save_size_bytes;
          rtc_inuse_next  = rtc_inuse;
          timestamp_next  = rtc_timestamp;
          savedtime_next  = rtc_savedtime;
          n_next          = '0;
          k_next          = '0;
          wait_next       = '0;
          state_next      = ST_RD_LO;
        end
      end

      // Also the first state after start, so it doubles as the empty /
      // RTC-only dispatch point once the snapshot is latched.
      ST_RD_LO: begin
        if (total_words(size_bytes_reg, rtc_inuse_reg) == 16'd0) begin
          state_next = ST_FINISH;
        end else if (ram_word_cnt == 16'd0) begin
          k_next     = '0;
          state_next = ST_RTC_EMIT;
        end else begin
          bk_rd      = 1'b1;
          wait_next  = '0;
          state_next = ST_WAIT_LO;
        end
      end

      ST_WAIT_LO: begin
        if (wait_reg == LAT_LAST) begin
          data_next[15:0] = bk_q;
          wait_next       = '0;
          state_next      = ST_RD_HI;
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end

      ST_RD_HI: begin
        hi_sel     = 1'b1;
        bk_rd      = 1'b1;
        wait_next  = '0;
        state_next = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        hi_sel = 1'b1;
        if (wait_reg == LAT_LAST) begin
          data_next[31:16] = bk_q;
          wait_next        = '0;
          state_next       = ST_EMIT;
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = !rtc_inuse_reg && (n_inc == ram_word_cnt);
        if (out_ready) begin
          n_next = n_inc;
          if (n_inc == ram_word_cnt) begin
            k_next     = '0;
            state_next = rtc_inuse_reg ? ST_RTC_EMIT : ST_FINISH;
          end else begin
            state_next = ST_RD_LO;
          end
        end
      end

      ST_RTC_EMIT: begin
        out_valid = 1'b1;
        out_data  = trailer_word;
        out_last  = (k_reg == RTC_LAST_K);
        if (out_ready) begin
          if (k_reg == RTC_LAST_K) begin
            state_next = ST_FINISH;
          end else begin
            k_next = k_reg + 2'd1;
          end
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // FINISH is excluded so an abort there cannot produce a second done.
    if (abort && state_reg != ST_IDLE && state_reg != ST_FINISH) begin
      state_next = ST_FINISH;
    end
  end

endmodule

// File: tb/tb_save_stream_reader.sv
// Randomized self-checking bench for save_stream_reader: a latency-accurate
// RAM model plus a queue of expected words built from the dump rules.
module tb_save_stream_reader;

  localparam int L = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [17:0] save_size_bytes;
  logic        rtc_inuse;
  logic [31:0] rtc_timestamp;
  logic [47:0] rtc_savedtime;
  logic        bk_rd;
  logic [16:0] bk_addr;
  logic [15:0] bk_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  save_stream_reader #(.READ_LATENCY(L), .ADDR_W(17)) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .save_size_bytes (save_size_bytes),
    .rtc_inuse       (rtc_inuse),
    .rtc_timestamp   (rtc_timestamp),
    .rtc_savedtime   (rtc_savedtime),
    .bk_rd           (bk_rd),
    .bk_addr         (bk_addr),
    .bk_q            (bk_q),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Backup RAM: data for a read strobed in cycle t shows up in cycle t+L.
  logic [15:0] mem  [0:65535];
  logic [15:0] pipe [0:15];
  always @(posedge clk_sys) begin
    pipe[0] <= bk_rd ? mem[bk_addr[15:0]] : 16'hDEAD;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end
  assign bk_q = pipe[L-1];

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int   ready_mode = 0;
  logic ready_gen  = 1'b1;
  logic force_low  = 1'b0;
  always @(posedge clk_sys) begin
    #1;
    ready_gen = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end
  assign out_ready = ready_gen && !force_low;

  logic [31:0] exp_q[$];
  int got = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) begin
          check_value("word", out_data, exp_q[got]);
          check_value("last", out_last, (got == exp_q.size() - 1));
        end else begin
          check_value("extra_word", got, exp_q.size());
        end
        got++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic build_exp(input logic [17:0] sz, input logic rtc,
                           input logic [31:0] ts, input logic [47:0] st);
    int n_ram;
    exp_q.delete();
    n_ram = int'(sz) / 4;
    for (int i = 0; i < n_ram; i++) exp_q.push_back({mem[2*i+1], mem[2*i]});
    if (rtc) begin
      exp_q.push_back(ts);
      exp_q.push_back(st[31:0]);
      exp_q.push_back({16'hFFFF, st[47:32]});
    end
  endtask

  // Returns the cycle in which start was high.
  task automatic begin_dump(input logic [17:0] sz, input logic rtc,
                            input logic [31:0] ts, input logic [47:0] st,
                            output int start_cyc);
    build_exp(sz, rtc, ts, st);
    got = 0;
    done_cnt = 0;
    save_size_bytes = sz;
    rtc_inuse = rtc;
    rtc_timestamp = ts;
    rtc_savedtime = st;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk_sys); #1;
    start = 1'b0;
    // Snapshot must be held; disturb the live inputs.
    save_size_bytes = 18'd131072;
    rtc_inuse = !rtc;
    rtc_timestamp = $urandom;
    rtc_savedtime = {16'($urandom), $urandom};
  endtask

  task automatic run_dump(input logic [17:0] sz, input logic rtc,
                          input logic [31:0] ts, input logic [47:0] st,
                          input int stall_at, input bit restart);
    int start_cyc, budget;
    bit stalled, restarted;
    logic [31:0] held;
    stalled = 0;
    restarted = 0;
    begin_dump(sz, rtc, ts, st, start_cyc);
    budget = 40 * (exp_q.size() + 3) + 100;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      start = 1'b0;
      if (restart && !restarted && exp_q.size() > 1 && got == exp_q.size() / 2) begin
        start = 1'b1;
        restarted = 1;
      end
      if (stall_at >= 0 && !stalled && got == stall_at && out_valid) begin
        force_low = 1'b1;
        held = out_data;
        repeat (20) begin
          @(negedge clk_sys);
          check_value("stall_valid", out_valid, 1'b1);
          check_value("stall_data", out_data, held);
          check_value("stall_rd", bk_rd, 1'b0);
          @(posedge clk_sys); #1;
        end
        force_low = 1'b0;
        stalled = 1;
      end
      @(posedge clk_sys); #1;
    end
    start = 1'b0;
    check_value("done_seen", (done_cnt != 0), 1'b1);
    check_value("word_count", got, exp_q.size());
    if (stall_at >= 0) check_value("stall_seen", stalled, 1'b1);
    if (exp_q.size() > 0) check_value("done_lat", done_cyc - last_acc_cyc, 1);
    else                  check_value("done_lat", done_cyc - start_cyc, 2);
    repeat (3) @(posedge clk_sys);
    #1;
    check_value("done_once", done_cnt, 1);
    check_value("busy_idle", busy, 1'b0);
    $display("dump size=%0d rtc=%0d words=%0d got=%0d", sz, rtc, exp_q.size(), got);
  endtask

  initial begin
    int sc;
    int guard;
    logic [17:0] sizes [3];
    sizes[0] = 18'd0;
    sizes[1] = 18'd512;
    sizes[2] = 18'd2048;

    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    save_size_bytes = '0;
    rtc_inuse = 1'b0;
    rtc_timestamp = '0;
    rtc_savedtime = '0;
    for (int h = 0; h < 65536; h++) mem[h] = 16'(h);

    repeat (3) @(posedge clk_sys);
    #1;
    check_value("reset_outs", {bk_rd, bk_addr, out_valid, out_data, out_last, busy, done}, 54'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_value("idle_busy", busy, 1'b0);

    // RAM[h]=h packing, ready held high.
    run_dump(18'd512, 1'b0, 32'h0, 48'h0, -1, 0);
    run_dump(18'd0, 1'b0, 32'h0, 48'h0, -1, 0);
    run_dump(18'd0, 1'b1, 32'hCAFE_F00D, 48'h1122_3344_5566, -1, 0);

    // abort together with start in IDLE: start ignored.
    @(posedge clk_sys); #1;
    done_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    abort = 1'b0;
    check_value("abort_start_idle", busy, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    check_value("abort_start_done", done_cnt, 0);

    for (int h = 0; h < 65536; h++) mem[h] = 16'($urandom);

    // RTC trailer, with a start pulse mid-dump that must be ignored.
    run_dump(18'd2048, 1'b1, 32'h1234_5678, 48'hAAAA_BBBB_CCCC, -1, 1);
    run_dump(18'd512, 1'b0, 32'h0, 48'h0, 5, 0);

    // Abort while word 10 is pending.
    begin_dump(18'd512, 1'b1, $urandom, {16'($urandom), $urandom}, sc);
    guard = 0;
    while (!(got == 10 && out_valid) && guard < 3000) begin
      if (got == 10) force_low = 1'b1;
      @(posedge clk_sys); #1;
      guard++;
    end
    check_value("abort_reach", {got[15:0], out_valid}, {16'd10, 1'b1});
    abort = 1'b1;
    @(posedge clk_sys); #1;
    abort = 1'b0;
    @(negedge clk_sys);
    check_value("abort_valid", out_valid, 1'b0);
    check_value("abort_rd", bk_rd, 1'b0);
    check_value("abort_last", out_last, 1'b0);
    check_value("abort_done", done, 1'b1);
    @(posedge clk_sys); #1;
    force_low = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_value("abort_busy", busy, 1'b0);
    check_value("abort_done_once", done_cnt, 1);
    check_value("abort_words", got, 10);
    $display("dump aborted at word %0d", got);

    // Random dumps under random back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      run_dump(sizes[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
               $urandom, {16'($urandom), $urandom}, -1, 0);
    end
    ready_mode = 0;

    // Asynchronous reset in the middle of a dump.
    begin_dump(18'd2048, 1'b1, $urandom, {16'($urandom), $urandom}, sc);
    guard = 0;
    while (got < 20 && guard < 3000) begin
      @(posedge clk_sys); #1;
      guard++;
    end
    check_value("reset_reach", got >= 20, 1'b1);
    check_value("reset_pre_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("reset_mid_outs", {bk_rd, bk_addr, out_valid, out_data, out_last, busy, done}, 54'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    check_value("reset_no_done", done_cnt, 0);
    check_value("reset_idle", busy, 1'b0);
    $display("dump reset after word %0d", got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
